bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
Parametrised N-digit BCD up/down counter with its own 7-segment scan driver. It generalises the fixed 8-digit counter-plus-display top in four ways: configurable digit count, a runtime-programmable count prescaler, a wrap/saturate mode, and leading-zero blanking. It also provides a terminal-count pulse for cascading. It sits between board switches/buttons and the Nexys-style AN/segment pins.

Parameters:
NUM_DIGITS, 8, number of BCD digits and anodes (legal 1..8)
DIV_W, 27, width of prescaler reload value
REFRESH_DIV, 6250, clk cycles per display digit slot (legal >= 1)
SEL_W, 3, width of load_sel; must be >= max(1, clog2(NUM_DIGITS))

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-low reset
en  in  1  count enable; gates prescaler and counting
up_down  in  1  1 = count up, 0 = count down
sat_mode  in  1  1 = saturate at limit, 0 = wrap
load  in  1  load load_val into digit load_sel
load_sel  in  SEL_W  digit index to load (0 = least significant)
load_val  in  4  BCD value to load
div_val  in  DIV_W  prescaler reload; count tick every div_val+1 cycles
blank_lz  in  1  1 = blank leading zero digits
count  out  4*NUM_DIGITS  current BCD value, digit i at [4i+3:4i]
tc  out  1  one-cycle terminal-count pulse
an  out  NUM_DIGITS  anode enables, active-low, one-hot-low
seg  out  7  segments {a,b,c,d,e,f,g}, active-low
dp  out  1  decimal point, active-low; tied 1 (off)

Behaviour:
- Reset is sampled at posedge clk when reset==0. Reset values: count=0, tc=0, an=all 1s, seg=7'b1111111, prescaler=0, refresh counter=0, scan index=0. dp is constant 1.
- Prescaler: runs only while en=1; holds its value when en=0. tick asserts in the cycle where prescaler==div_val, and the prescaler then returns to 0. div_val=0 gives a tick every enabled cycle. If div_val is changed below the current prescaler value, the prescaler wraps through its full DIV_W range; this is accepted.
- Priority per cycle: reset > load > tick.
- Load: updates only digit load_sel; all other digits hold. load_val 10..15 is clamped to 9. load_sel >= NUM_DIGITS is ignored. A tick in the same cycle as load is dropped, and tc stays 0.
- Up tick: digit0 increments. A digit at 9 becomes 0 and carries into the next digit, rippling across all digits in a single cycle. At all-9s: tc=1 for that cycle; wrap mode gives all 0s, sat mode holds all 9s.
- Down tick: digit0 decrements. A digit at 0 becomes 9 and borrows from the next digit. At all-0s: tc=1; wrap mode gives all 9s, sat mode holds all 0s.
- tc is registered, asserts only on a tick at the terminal value for the current direction, and is 0 otherwise.
- up_down and sat_mode are sampled on the tick cycle. A direction change takes effect on the next tick.
- Scanner: the refresh counter counts 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 the scan index advances, wrapping from NUM_DIGITS-1 to 0. This runs independently of en.
- an and seg are both registered from the same scan index, so they change in the same clk edge (1-cycle latency from the index update).
- seg decodes the digit at the scan index, 0..9, active-low (0 → 0000001, 8 → 0000000).
- Blanking: when blank_lz=1, digit i (i>0) is blanked (seg=1111111) if it and all higher digits are 0. Digit 0 is never blanked.
- NUM_DIGITS=1: load_sel is ignored apart from the range check; the scan index stays 0.

Test Plan:
- NUM_DIGITS=4, div_val=0, en=1, up: reset then 9999 ticks → count=16'h9999, tc=0; the next tick gives 16'h0000 with tc=1 for exactly 1 cycle.
- Down, sat_mode=1 from 0000: 3 ticks → count stays 0000, tc pulses on each tick; switch sat_mode=0, one tick → 9999.
- Load 7 to sel=2, then 12 to sel=0, then sel=5 (=4 digits) → 0700, 0709, unchanged. Load coinciding with a tick → no increment, tc=0.
- div_val=3, en toggled 1,1,0,0,1,1 → first tick after the 4th enabled cycle; prescaler value holds during en=0.
- REFRESH_DIV=4, count=0042, blank_lz=1 → an sequence 1110,1101,1011,0111 every 4 cycles. seg shows 2 (0010010) and 4 (1001100), then blank, blank. With blank_lz=0, "0" (0000001) shows on digits 2 and 3.
- Assert reset low mid-count (count=0357, an=1011) → next edge count=0, an=1111, seg=1111111, tc=0; counting resumes from 0001 after release.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with programmable prescaler, wrap/saturate limit
// handling, terminal-count pulse and a multiplexed active-low 7-segment driver.
module bcd_scan_counter #(
   parameter int NUM_DIGITS  = 8,
   parameter int DIV_W       = 27,
   parameter int REFRESH_DIV = 6250,
   parameter int SEL_W       = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up_down,
   input  logic                    sat_mode,
   input  logic                    load,
   input  logic [SEL_W-1:0]        load_sel,
   input  logic [3:0]              load_val,
   input  logic [DIV_W-1:0]        div_val,
   input  logic                    blank_lz,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    tc,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]        pre;
   logic                    tick;
   logic [4*NUM_DIGITS-1:0] step_cnt;
   logic [4*NUM_DIGITS-1:0] load_cnt;
   logic                    at_limit;
   logic [3:0]              load_digit;
   logic [REF_W-1:0]        ref_cnt;
   logic [IDX_W-1:0]        scan_idx;
   logic [NUM_DIGITS:0]     lead_zero;
   logic [3:0]              cur_digit;
   logic                    cur_blank;

   assign dp         = 1'b1;
   assign tick       = en && (pre == div_val);
   assign load_digit = (load_val > 4'd9) ? 4'd9 : load_val;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Single-cycle ripple: a carry/borrow surviving past the top digit means
   // the whole counter sat at its terminal value for this direction.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign every output a
      // default first, so the loop reads updated values and no latch is inferred.
      step_cnt = count;
      at_limit = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (at_limit) begin
            if (up_down) begin
               if (count[4*i +: 4] == 4'd9) begin
                  step_cnt[4*i +: 4] = 4'd0;
               end else begin
                  step_cnt[4*i +: 4] = count[4*i +: 4] + 4'd1;
                  at_limit = 1'b0;
               end
            end else begin
               if (count[4*i +: 4] == 4'd0) begin
                  step_cnt[4*i +: 4] = 4'd9;
               end else begin
                  step_cnt[4*i +: 4] = count[4*i +: 4] - 4'd1;
                  at_limit = 1'b0;
               end
            end
         end
      end
   end

   // Out-of-range load_sel matches no digit, so the load leaves count unchanged.
   always_comb begin
      load_cnt = count;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (int'(load_sel) == i) load_cnt[4*i +: 4] = load_digit;
      end
   end

   always_comb begin
      lead_zero = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lead_zero[i] = lead_zero[i+1] && (count[4*i +: 4] == 4'd0);
      end
   end

   always_comb begin
      cur_digit = count[3:0];
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            cur_digit = count[4*i +: 4];
            cur_blank = blank_lz && (i > 0) && lead_zero[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         pre   <= '0;
         count <= '0;
         tc    <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (en) pre <= (pre == div_val) ? '0 : pre + DIV_W'(1);
         if (load) begin
            count <= load_cnt;
         end else if (tick) begin
            tc <= at_limit;
            if (!(at_limit && sat_mode)) count <= step_cnt;
         end
      end
   end

   // an and seg both follow the registered scan index, so they switch together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ref_cnt  <= '0;
         scan_idx <= '0;
         an       <= '1;
         seg      <= 7'b1111111;
      end else begin
         if (ref_cnt == REF_LAST) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
         end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
         end
         an  <= ~(NUM_DIGITS'(1) << scan_idx);
         seg <= cur_blank ? 7'b1111111 : seg_decode(cur_digit);
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: an integer-valued reference model
// pushes expected outputs per cycle; a monitor pops and compares them.
module tb_bcd_scan_counter;

   localparam int ND    = 4;
   localparam int DW    = 8;
   localparam int RDIV  = 4;
   localparam int SW    = 3;
   localparam int MAXV  = 9999;

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic            up_down;
   logic            sat_mode;
   logic            load;
   logic [SW-1:0]   load_sel;
   logic [3:0]      load_val;
   logic [DW-1:0]   div_val;
   logic            blank_lz;
   logic [4*ND-1:0] count;
   logic            tc;
   logic [ND-1:0]   an;
   logic [6:0]      seg;
   logic            dp;

   bcd_scan_counter #(
      .NUM_DIGITS(ND), .DIV_W(DW), .REFRESH_DIV(RDIV), .SEL_W(SW)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .sat_mode(sat_mode),
      .load(load), .load_sel(load_sel), .load_val(load_val), .div_val(div_val),
      .blank_lz(blank_lz), .count(count), .tc(tc), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            rst_n;
      logic            en;
      logic            ud;
      logic            sat;
      logic            ld;
      logic [SW-1:0]   sel;
      logic [3:0]      lv;
      logic [DW-1:0]   div;
      logic            blz;
   } stim_t;

   typedef struct packed {
      logic [4*ND-1:0] cnt;
      logic            tc;
      logic [ND-1:0]   an;
      logic [6:0]      seg;
   } exp_t;

   stim_t s;
   exp_t  q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   // Reference model state: counter as a plain integer, prescaler as an
   // integer, and the number of clock edges since reset was released.
   int m_val = 0;
   int m_p   = 0;
   int m_k   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*ND-1:0] to_bcd(input int v);
      logic [4*ND-1:0] r = '0;
      for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         default: return 7'b0000100;
      endcase
   endfunction

   // Apply s at the falling edge and push what the next rising edge must produce.
   task automatic cycle();
      exp_t e;
      int   idx, pw, v, old;
      bit   tk;
      @(negedge clk);
      reset = s.rst_n; en = s.en; up_down = s.ud; sat_mode = s.sat; load = s.ld;
      load_sel = s.sel; load_val = s.lv; div_val = s.div; blank_lz = s.blz;
      if (!s.rst_n) begin
         m_val = 0; m_p = 0; m_k = 0;
         e.cnt = '0; e.tc = 1'b0; e.an = '1; e.seg = 7'b1111111;
      end else begin
         idx   = (m_k / RDIV) % ND;
         pw    = pow10(idx);
         e.an  = ND'(~(1 << idx));
         e.seg = (s.blz && idx > 0 && m_val < pw) ? 7'b1111111 : seg_ref((m_val / pw) % 10);
         tk    = s.en && (m_p == int'(s.div));
         if (s.en) m_p = tk ? 0 : (m_p + 1) % (1 << DW);
         e.tc  = 1'b0;
         if (s.ld) begin
            if (int'(s.sel) < ND) begin
               v     = (s.lv > 9) ? 9 : int'(s.lv);
               pw    = pow10(int'(s.sel));
               old   = (m_val / pw) % 10;
               m_val = m_val + (v - old) * pw;
            end
         end else if (tk) begin
            if (s.ud) begin
               if (m_val == MAXV) begin e.tc = 1'b1; if (!s.sat) m_val = 0; end
               else m_val = m_val + 1;
            end else begin
               if (m_val == 0) begin e.tc = 1'b1; if (!s.sat) m_val = MAXV; end
               else m_val = m_val - 1;
            end
         end
         m_k++;
         e.cnt = to_bcd(m_val);
      end
      q.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("count", 32'(count), 32'(e.cnt));
            check("tc", 32'(tc), 32'(e.tc));
            check("an", 32'(an), 32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(dp), 32'd1);
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit found;
      s = '0;
      s.ud = 1'b1;

      // Count up through the full range with a tick every cycle.
      cycle(); cycle();
      s.rst_n = 1'b1; s.en = 1'b1; s.div = '0;
      for (int i = 0; i < MAXV; i++) cycle();
      after_edge();
      check("full_9999", 32'(count), 32'h9999);
      check("full_tc_low", 32'(tc), 32'd0);
      cycle(); after_edge();
      check("wrap_0000", 32'(count), 32'h0000);
      check("wrap_tc", 32'(tc), 32'd1);
      s.en = 1'b0; cycle(); after_edge();
      check("tc_one_cycle", 32'(tc), 32'd0);

      // Down with saturation at zero, then wrap.
      s.en = 1'b1; s.ud = 1'b0; s.sat = 1'b1;
      repeat (3) cycle();
      after_edge();
      check("sat_hold_0", 32'(count), 32'h0000);
      s.sat = 1'b0; cycle(); after_edge();
      check("down_wrap", 32'(count), 32'h9999);

      // Digit loads, clamping, out-of-range select, load over tick.
      s.rst_n = 1'b0; cycle();
      s.rst_n = 1'b1; s.en = 1'b0; s.ld = 1'b1; s.ud = 1'b1;
      s.sel = 3'd2; s.lv = 4'd7;  cycle(); after_edge();
      check("load_0700", 32'(count), 32'h0700);
      s.sel = 3'd0; s.lv = 4'd12; cycle(); after_edge();
      check("load_clamp", 32'(count), 32'h0709);
      s.sel = 3'd5; s.lv = 4'd3;  cycle(); after_edge();
      check("load_oob", 32'(count), 32'h0709);
      s.en = 1'b1; s.sel = 3'd1; s.lv = 4'd0; cycle(); after_edge();
      check("load_drops_tick", 32'(count), 32'h0709);
      s.ld = 1'b0;

      // Prescaler with div_val=3 and en gaps.
      s.rst_n = 1'b0; s.en = 1'b0; cycle();
      s.rst_n = 1'b1; s.div = 8'd3;
      s.en = 1'b1; cycle(); cycle();
      s.en = 1'b0; cycle(); cycle();
      s.en = 1'b1; cycle(); after_edge();
      check("presc_no_tick", 32'(count), 32'h0000);
      cycle(); after_edge();
      check("presc_tick", 32'(count), 32'h0001);

      // Scanner and leading-zero blanking on 0042.
      s.rst_n = 1'b0; s.en = 1'b0; cycle();
      s.rst_n = 1'b1; s.ld = 1'b1;
      s.sel = 3'd0; s.lv = 4'd2; cycle();
      s.sel = 3'd1; s.lv = 4'd4; cycle();
      s.ld = 1'b0; s.blz = 1'b1;
      repeat (20) cycle();
      s.blz = 1'b0;
      repeat (16) cycle();

      // Reset mid-count while digit 2 is being shown.
      s.ld = 1'b1;
      s.sel = 3'd0; s.lv = 4'd7; cycle();
      s.sel = 3'd1; s.lv = 4'd5; cycle();
      s.sel = 3'd2; s.lv = 4'd3; cycle();
      s.ld = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         cycle(); after_edge();
         if (an == 4'b1011) found = 1'b1;
      end
      check("an_1011_seen", 32'(found), 32'd1);
      check("pre_reset_cnt", 32'(count), 32'h0357);
      s.rst_n = 1'b0; cycle(); after_edge();
      check("rst_count", 32'(count), 32'h0000);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      s.rst_n = 1'b1; s.en = 1'b1; s.div = '0; s.ud = 1'b1; cycle(); after_edge();
      check("resume_0001", 32'(count), 32'h0001);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         s.rst_n = ($urandom_range(0, 199) != 0);
         s.en    = ($urandom_range(0, 3) != 0);
         s.ud    = ($urandom_range(0, 15) != 0) ? s.ud : ~s.ud;
         s.sat   = ($urandom_range(0, 31) != 0) ? s.sat : ~s.sat;
         s.ld    = ($urandom_range(0, 15) == 0);
         s.sel   = SW'($urandom_range(0, 7));
         s.lv    = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) s.div = DW'($urandom_range(0, 3));
         s.blz   = ($urandom_range(0, 63) != 0) ? s.blz : ~s.blz;
         cycle();
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
